// File: rtl/stage_reg_pkg.sv
// Shared types and constants for the stage_reg two-entry skid buffer.
package stage_reg_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_WIDTH     = 32;

  // Encoding equals the number of entries held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/stage_reg_slot.sv
// One payload register: async reset and synchronous clear to CLEAR_VAL, load enable.
module stage_reg_slot
  import stage_reg_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= CLEAR_VAL;
    end else if (clear) begin
      q <= CLEAR_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/stage_reg.sv
// Two-entry skid buffer pipeline stage with registered ready/valid on both sides.
// Define STAGE_REG_PERF_EN to build the 32-bit downstream stall counter; otherwise stall_cnt is 0.
module stage_reg
  import stage_reg_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  state_t           state, state_nxt;
  logic             accept, deliver;
  logic             main_load, skid_load, main_from_skid;
  logic [WIDTH-1:0] main_d, skid_q;

  // Handshake outputs decode from the state flops only, so ready never depends on out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid  & in_ready  & enable & ~clear;
  assign deliver   = out_valid & out_ready & enable & ~clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          main_load = 1'b1;
        end
      end
      ONE: begin
        if (accept && !deliver) begin
          state_nxt = FULL;
          skid_load = 1'b1;
        end else if (deliver && !accept) begin
          state_nxt = EMPTY;
        end else if (accept && deliver) begin
          main_load = 1'b1;
        end
      end
      FULL: begin
        if (deliver) begin
          state_nxt      = ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (clear) begin
      state_nxt = EMPTY;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  stage_reg_slot #(
    .WIDTH     (WIDTH),
    .CLEAR_VAL (CLEAR_VAL)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .clear (clear),
    .d     (main_d),
    .q     (out_data)
  );

  stage_reg_slot #(
    .WIDTH     (WIDTH),
    .CLEAR_VAL (CLEAR_VAL)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clear (clear),
    .d     (in_data),
    .q     (skid_q)
  );

  always_comb begin
    occupancy = 2'd0;
    unique case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

`ifdef STAGE_REG_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clear) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && enable) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_stage_reg.sv
// Scoreboard bench for stage_reg: queue-level reference model, randomized and directed stimulus.
module tb_stage_reg;
  import stage_reg_pkg::*;

  localparam int             W  = 32;
  localparam logic [W-1:0]   CV = 32'h0BAD_C0DE;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         enable = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  logic [31:0]  stall_cnt;

  always #5 clk = ~clk;

  stage_reg #(
    .WIDTH     (W),
    .CLEAR_VAL (CV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] model_q[$];   // entries the stage should be holding, oldest first
  logic [W-1:0] sb_q[$];      // accepted payloads still owed to the downstream side
  logic [W-1:0] last_out = CV;
  logic [31:0]  cnt_exp = '0;
  logic [W-1:0] mon_exp;
  bit           acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [W-1:0] exp_data;
    exp_data = (model_q.size() > 0) ? model_q[0] : last_out;
    check({tag, "_in_ready"},  64'(in_ready),  64'(model_q.size() < 2));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(model_q.size() > 0));
    check({tag, "_occupancy"}, 64'(occupancy), 64'(model_q.size()));
    check({tag, "_out_data"},  64'(out_data),  64'(exp_data));
`ifdef STAGE_REG_PERF_EN
    check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(cnt_exp));
`else
    check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
  endtask

  // Called just after a rising edge; returns whether the model accepted the payload.
  task automatic step(input logic v, input logic [W-1:0] d, input logic ordy,
                      input logic en, input logic clr, output bit accepted);
    bit del;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    enable    = en;
    clear     = clr;
    @(negedge clk);
    check_outputs("step");
    accepted = v && (model_q.size() < 2) && en && !clr;
    del      = (model_q.size() > 0) && ordy && en && !clr;
    if (clr) sb_q.delete();
    else if (accepted) sb_q.push_back(d);
    @(posedge clk);
    if (clr) begin
      model_q.delete();
      last_out = CV;
      cnt_exp  = '0;
    end else begin
      if ((model_q.size() > 0) && !ordy && en) cnt_exp++;
      if (del) last_out = model_q.pop_front();
      if (accepted) model_q.push_back(d);
    end
    #1;
  endtask

  task automatic go(input logic v, input logic [W-1:0] d, input logic ordy,
                    input logic en, input logic clr);
    bit dummy;
    step(v, d, ordy, en, clr, dummy);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    enable    = 1'b0;
    clear     = 1'b0;
    model_q.delete();
    sb_q.delete();
    last_out = CV;
    cnt_exp  = '0;
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed downstream transfer must match the oldest owed payload.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && enable && !clear) begin
      if (sb_q.size() == 0) begin
        check("mon_unexpected_output", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_exp = sb_q.pop_front();
        check("mon_out_data", 64'(out_data), 64'(mon_exp));
      end
    end
  end

  initial begin
    #2;
    do_reset();

    // Single payload, one-cycle latency.
    go(1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0);
    go(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Back-to-back stream at full rate.
    for (int i = 1; i <= 8; i++) go(1'b1, 32'(i), 1'b1, 1'b1, 1'b0);
    go(1'b0, '0, 1'b1, 1'b1, 1'b0);
    go(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Downstream stall fills both entries; third payload waits upstream.
    go(1'b1, 32'h10, 1'b0, 1'b1, 1'b0);
    go(1'b1, 32'h11, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) go(1'b1, 32'h12, 1'b0, 1'b1, 1'b0);
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) step(1'b1, 32'h12, 1'b1, 1'b1, 1'b0, acc);
    if (!acc) check("req037_accept_bound", 64'd0, 64'd1);
    for (int i = 0; i < 3; i++) go(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Full stage frozen by enable=0, then drained.
    go(1'b1, 32'h20, 1'b0, 1'b1, 1'b0);
    go(1'b1, 32'h21, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) go(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) go(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Clear while full discards everything including the payload offered that cycle.
    go(1'b1, 32'h30, 1'b0, 1'b1, 1'b0);
    go(1'b1, 32'h31, 1'b0, 1'b1, 1'b0);
    go(1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b1);
    go(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle while holding one entry, then restart from empty.
    go(1'b1, 32'h77, 1'b0, 1'b1, 1'b0);
    go(1'b0, '0, 1'b0, 1'b1, 1'b0);
    #2;
    do_reset();
    go(1'b1, 32'h88, 1'b1, 1'b1, 1'b0);
    go(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Randomized traffic with stalls, freezes and occasional flushes.
    for (int i = 0; i < 1500; i++) begin
      go(($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 2) != 0),
         ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0));
    end

    for (int i = 0; i < 3; i++) go(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
